// File: rtl/rs422_uart_rx.sv
// 8N1 RS422 UART receiver that samples each bit at its centre.
// Produces a byte/strobe/ack stream with framing-error and overrun pulses.
module rs422_uart_rx #(
    parameter int BAUD_RATE       = 115200,
    parameter int CLOCK_FREQUENCY = 100000000
) (
    input  logic       OPB_CLK,
    input  logic       OPB_RST_N,
    input  logic       RX,
    output logic [7:0] DATA_OUT,
    output logic       DATA_OUT_STB,
    input  logic       DATA_OUT_ACK,
    output logic       FRAME_ERR,
    output logic       OVERRUN,
    output logic       BUSY
);
    localparam int CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t           state, state_n;
    logic             rx_meta, rx_s;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shreg, shreg_n;
    logic             load, ovr, ferr;

    always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
        if (!OPB_RST_N) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
        if (!OPB_RST_N) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
        end
    end

    // cnt holds (cycles since the last sample point) - 1, so each sample
    // fires when cnt reaches the last count of its interval.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        load      = 1'b0;
        ovr       = 1'b0;
        ferr      = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    shreg_n = {rx_s, shreg[7:1]};
                    if (bit_idx == 3'd7) state_n = STOP;
                    else bit_idx_n = bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        state_n = IDLE;
                        if (!DATA_OUT_STB || DATA_OUT_ACK) load = 1'b1;
                        else ovr = 1'b1;
                    end else begin
                        state_n = BREAK;
                        ferr    = 1'b1;
                    end
                end
            end
            BREAK: begin
                cnt_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // A new byte in the same cycle as an ack replaces the old one, STB stays up.
    always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
        if (!OPB_RST_N) begin
            DATA_OUT     <= 8'h00;
            DATA_OUT_STB <= 1'b0;
            FRAME_ERR    <= 1'b0;
            OVERRUN      <= 1'b0;
        end else begin
            FRAME_ERR <= ferr;
            OVERRUN   <= ovr;
            if (load) begin
                DATA_OUT     <= shreg;
                DATA_OUT_STB <= 1'b1;
            end else if (DATA_OUT_STB && DATA_OUT_ACK) begin
                DATA_OUT_STB <= 1'b0;
            end
        end
    end

    assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_rs422_uart_rx.sv
// Directed bench for rs422_uart_rx at 16 clocks per bit.
module tb_rs422_uart_rx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] dout;
    logic       stb, ack, ferr, ovr, busy;
    logic       ack_drv = 1'b0;
    logic       ack_tie = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    int cyc = 0, rises = 0, rise_cyc = 0, stb_hi = 0;
    int n_ferr = 0, n_ovr = 0, ovr_cyc = 0, n_busy = 0;
    logic stb_q = 1'b0;
    logic [7:0] rxq[$];

    assign ack = ack_tie ? stb : ack_drv;

    rs422_uart_rx #(.BAUD_RATE(100000), .CLOCK_FREQUENCY(1600000)) dut (
        .OPB_CLK(clk), .OPB_RST_N(rst_n), .RX(rx),
        .DATA_OUT(dout), .DATA_OUT_STB(stb), .DATA_OUT_ACK(ack),
        .FRAME_ERR(ferr), .OVERRUN(ovr), .BUSY(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (stb && !stb_q) begin
            rises++;
            rise_cyc = cyc;
            rxq.push_back(dout);
        end
        stb_q = stb;
        if (stb) stb_hi++;
        if (ferr) n_ferr++;
        if (ovr) begin
            n_ovr++;
            ovr_cyc = cyc;
        end
        if (busy) n_busy++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Called at a negedge; s is the posedge count just before the start bit.
    task automatic send_frame(input logic [7:0] b, input logic stopb, output int s);
        logic [9:0] f;
        f = {stopb, b, 1'b0};
        s = cyc;
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (16) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic do_ack();
        check("stb_before_ack", int'(stb), 1);
        ack_drv = 1'b1;
        @(negedge clk);
        ack_drv = 1'b0;
        check("stb_after_ack", int'(stb), 0);
    endtask

    initial begin
        int s, s2, r0, f0, o0, b0, h0, hold_busy, q0, mism;

        repeat (3) @(negedge clk);
        check("rst_data", int'(dout), 0);
        check("rst_stb", int'(stb), 0);
        check("rst_ferr", int'(ferr), 0);
        check("rst_ovr", int'(ovr), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 1: basic receive, exact strobe latency, held until ack
        r0 = rises; f0 = n_ferr; o0 = n_ovr;
        send_frame(8'hA5, 1'b1, s);
        repeat (50) @(negedge clk);
        check("t1_rise_count", rises - r0, 1);
        check("t1_latency", rise_cyc - s, 155);
        check("t1_data", int'(dout), 8'hA5);
        check("t1_stb_held", int'(stb), 1);
        do_ack();
        check("t1_ferr", n_ferr - f0, 0);
        check("t1_ovr", n_ovr - o0, 0);
        // ack while STB low must not matter
        ack_drv = 1'b1;
        repeat (3) @(negedge clk);
        ack_drv = 1'b0;

        // 2: start glitch
        r0 = rises; f0 = n_ferr; o0 = n_ovr; b0 = n_busy;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        check("t2_busy_cycles", n_busy - b0, 8);
        check("t2_busy_end", int'(busy), 0);
        check("t2_no_stb", rises - r0, 0);
        check("t2_no_err", (n_ferr - f0) + (n_ovr - o0), 0);

        // 3: framing error, break hold, recovery
        r0 = rises; f0 = n_ferr;
        send_frame(8'h3C, 1'b0, s);
        rx = 1'b0;
        hold_busy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            hold_busy += int'(busy);
        end
        check("t3_hold_busy", hold_busy, 100);
        rx = 1'b1;
        repeat (32) @(negedge clk);
        check("t3_ferr_once", n_ferr - f0, 1);
        check("t3_no_stb", rises - r0, 0);
        check("t3_idle", int'(busy), 0);
        send_frame(8'h55, 1'b1, s);
        repeat (10) @(negedge clk);
        check("t3_rx55_rise", rises - r0, 1);
        check("t3_rx55_data", int'(dout), 8'h55);
        do_ack();

        // 4: overrun with ack held low
        r0 = rises; o0 = n_ovr; h0 = stb_hi;
        send_frame(8'h11, 1'b1, s);
        send_frame(8'h22, 1'b1, s2);
        repeat (10) @(negedge clk);
        check("t4_rise", rises - r0, 1);
        check("t4_ovr_once", n_ovr - o0, 1);
        check("t4_ovr_time", ovr_cyc - s2, 155);
        check("t4_data_kept", int'(dout), 8'h11);
        do_ack();
        repeat (40) @(negedge clk);
        check("t4_no_more_stb", rises - r0, 1);

        // 5: streaming with ack tied to strobe
        ack_tie = 1'b1;
        r0 = rises; f0 = n_ferr; o0 = n_ovr; h0 = stb_hi; q0 = rxq.size();
        for (int i = 0; i < 256; i++) send_frame(8'(i), 1'b1, s);
        repeat (20) @(negedge clk);
        check("t5_rises", rises - r0, 256);
        check("t5_stb_width", stb_hi - h0, 256);
        check("t5_ferr", n_ferr - f0, 0);
        check("t5_ovr", n_ovr - o0, 0);
        mism = 0;
        for (int i = 0; i < 256; i++)
            if (q0 + i >= rxq.size() || rxq[q0 + i] != 8'(i)) mism++;
        check("t5_data_order", mism, 0);
        ack_tie = 1'b0;

        // 6: reset during data bit 4
        send_frame(8'h5A, 1'b1, s);
        repeat (5) @(negedge clk);
        check("t6_pre_stb", int'(stb), 1);
        r0 = rises;
        begin
            logic [9:0] f;
            f = {1'b1, 8'hF0, 1'b0};
            for (int i = 0; i < 5; i++) begin
                rx = f[i];
                repeat (16) @(negedge clk);
            end
            rx = f[5];
            repeat (8) @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_data", int'(dout), 0);
        check("t6_rst_stb", int'(stb), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_err", int'(ferr) + int'(ovr), 0);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("t6_no_partial", rises - r0, 0);
        send_frame(8'h81, 1'b1, s);
        repeat (10) @(negedge clk);
        check("t6_rx81_rise", rises - r0, 1);
        check("t6_rx81_data", int'(dout), 8'h81);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
